// File: rtl/median_window_sequencer.sv
// Walks a frame pixel by pixel, gathers each 3x3 neighbourhood from the source
// image (zero padding at the borders), hands it to a median datapath and writes the result back.
module median_window_sequencer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [71:0]       win_data,
    input  logic              res_valid,
    input  logic [7:0]        res_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_PRESENT,
        ST_WAIT_RES,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic [3:0]        tap_reg;
    logic [ADDR_W-1:0] pix_addr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              win_valid_reg;
    logic              cap_en_reg;
    logic              cap_inb_reg;
    logic [3:0]        cap_tap_reg;

    logic [1:0]        dy_idx;
    logic [1:0]        dx_idx;
    logic              row_ok;
    logic              col_ok;
    logic              tap_inb;
    logic [ADDR_W-1:0] tap_row_base;
    logic [ADDR_W-1:0] tap_addr;

    // Split the tap index into row/column offset indices (0 means -1, 2 means +1).
    always_comb begin
        dy_idx = 2'd0;
        dx_idx = 2'd0;
        if (tap_reg >= 4'd6) begin
            dy_idx = 2'd2;
            dx_idx = 2'(tap_reg - 4'd6);
        end else if (tap_reg >= 4'd3) begin
            dy_idx = 2'd1;
            dx_idx = 2'(tap_reg - 4'd3);
        end else begin
            dx_idx = 2'(tap_reg);
        end
    end

    always_comb begin
        row_ok = 1'b1;
        col_ok = 1'b1;
        tap_row_base = pix_addr_reg;
        tap_addr = pix_addr_reg;
        if (dy_idx == 2'd0) begin
            row_ok = (row_reg != '0);
            tap_row_base = pix_addr_reg - ROW_STRIDE;
        end else if (dy_idx == 2'd2) begin
            row_ok = (row_reg != ROW_LAST);
            tap_row_base = pix_addr_reg + ROW_STRIDE;
        end
        if (dx_idx == 2'd0) begin
            col_ok = (col_reg != '0);
            tap_addr = tap_row_base - ADDR_ONE;
        end else if (dx_idx == 2'd2) begin
            col_ok = (col_reg != COL_LAST);
            tap_addr = tap_row_base + ADDR_ONE;
        end else begin
            tap_addr = tap_row_base;
        end
        tap_inb = row_ok && col_ok;
    end

    assign mem_rd_en   = (state_reg == ST_FETCH) && tap_inb;
    assign mem_rd_addr = tap_addr;
    assign wr_en       = (state_reg == ST_WAIT_RES) && res_valid;
    assign wr_addr     = pix_addr_reg;
    assign wr_data     = res_data;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign win_valid   = win_valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            tap_reg       <= '0;
            pix_addr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            win_valid_reg <= 1'b0;
            cap_en_reg    <= 1'b0;
            cap_inb_reg   <= 1'b0;
            cap_tap_reg   <= '0;
        end else begin
            done_reg   <= 1'b0;
            cap_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_FETCH;
                        row_reg      <= '0;
                        col_reg      <= '0;
                        tap_reg      <= '0;
                        pix_addr_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Remember which tap was issued so next cycle's read data lands in it.
                    cap_en_reg  <= 1'b1;
                    cap_tap_reg <= tap_reg;
                    cap_inb_reg <= tap_inb;
                    if (tap_reg == 4'd8) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        tap_reg <= tap_reg + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    state_reg     <= ST_PRESENT;
                    win_valid_reg <= 1'b1;
                end
                ST_PRESENT: begin
                    if (win_ready) begin
                        win_valid_reg <= 1'b0;
                        state_reg     <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        state_reg <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    tap_reg <= '0;
                    if (col_reg == COL_LAST) begin
                        col_reg <= '0;
                        if (row_reg == ROW_LAST) begin
                            row_reg      <= '0;
                            pix_addr_reg <= '0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            row_reg      <= row_reg + 1'b1;
                            pix_addr_reg <= pix_addr_reg + ADDR_ONE;
                            state_reg    <= ST_FETCH;
                        end
                    end else begin
                        col_reg      <= col_reg + 1'b1;
                        pix_addr_reg <= pix_addr_reg + ADDR_ONE;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // One register per window tap; out-of-bounds taps load zero instead of bus data.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            logic [7:0] tap_data_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tap_data_reg <= 8'h00;
                end else if (cap_en_reg && (cap_tap_reg == 4'(gi))) begin
                    tap_data_reg <= cap_inb_reg ? mem_rd_data : 8'h00;
                end
            end
            assign win_data[8*gi +: 8] = tap_data_reg;
        end
    endgenerate

endmodule

// File: doc/median_window_sequencer.md
MEDIAN_WINDOW_SEQUENCER -- requirements
Module: median_window_sequencer

Interface
REQ-001 Parameter IMG_W, default 640, image width in pixels.
REQ-002 Parameter IMG_H, default 480, image height in pixels.
REQ-003 Parameter ADDR_W, default 19, width of the pixel address (IMG_W*IMG_H <= 2^ADDR_W).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle frame start request; sampled only in IDLE.
REQ-007 busy  output  1  high from the first cycle after start is accepted until DONE is entered.
REQ-008 done  output  1  one-cycle pulse when the frame is complete.
REQ-009 mem_rd_en  output  1  source image read strobe.
REQ-010 mem_rd_addr  output  ADDR_W  read address, row*IMG_W+col.
REQ-011 mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 win_valid  output  1  3x3 window presented to the median datapath.
REQ-013 win_ready  input  1  datapath accepts the window.
REQ-014 win_data  output  72  window taps; tap k in bits [8k+7:8k]; k=0 top-left, row-major, k=4 centre.
REQ-015 res_valid  input  1  median result valid from the datapath.
REQ-016 res_data  input  8  median result.
REQ-017 wr_en, wr_addr[ADDR_W], wr_data[8]  outputs  filtered-frame write port; one write per pixel.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, PRESENT, WAIT_RES, ADVANCE, DONE.
REQ-019 IDLE, start=1 -> FETCH; row=0, col=0, tap=0.
REQ-020 FETCH: one tap per cycle, tap 0..8, offsets dy=tap/3-1, dx=tap%3-1.
REQ-021 In-bounds tap (0<=col+dx<IMG_W, 0<=row+dy<IMG_H): mem_rd_en=1 and mem_rd_addr=(row+dy)*IMG_W+(col+dx).
REQ-022 Out-of-bounds tap: mem_rd_en=0; the tap register is loaded with 8'h00 in the cycle its read data would have returned.
REQ-023 Every tap occupies exactly one FETCH cycle, in or out of bounds.
REQ-024 Returned mem_rd_data is written to the tap register of the tap issued in the previous cycle.
REQ-025 After tap 8 is issued, FETCH -> DRAIN for 1 cycle to capture tap 8, then -> PRESENT.
REQ-026 PRESENT: win_valid=1, win_data stable; the window transfers on the edge with win_valid&win_ready, then -> WAIT_RES.
REQ-027 PRESENT with win_ready=0: hold win_valid and win_data unchanged, indefinitely.
REQ-028 WAIT_RES, res_valid=1: in the same cycle wr_en=1, wr_addr=row*IMG_W+col, wr_data=res_data, then -> ADVANCE.
REQ-029 res_valid outside WAIT_RES is ignored; no write.
REQ-030 ADVANCE: col+1; at col=IMG_W-1, col=0 and row+1; at the last pixel (IMG_W-1, IMG_H-1) -> DONE, else -> FETCH with tap=0.
REQ-031 DONE: done=1 for exactly 1 cycle, busy=0, -> IDLE.
REQ-032 start outside IDLE is ignored.
REQ-033 Minimum per-pixel latency is 13 cycles: 9 FETCH, 1 DRAIN, 1 PRESENT, 1 WAIT_RES, 1 ADVANCE. This holds with win_ready=1 and res_valid arriving 1 cycle after the transfer.
REQ-034 Address arithmetic is unsigned ADDR_W. Out-of-bounds taps never drive mem_rd_addr into use; the address value is don't-care when mem_rd_en=0.
REQ-035 mem_rd_en, win_valid and wr_en are never high together.

Reset
REQ-036 Reset asserted in any state, including mid-frame: FSM -> IDLE immediately. busy, done, mem_rd_en, win_valid and wr_en = 0. row, col and tap = 0. Tap registers = 8'h00.
REQ-037 After reset is released, no partial-frame write occurs; a new start restarts at pixel (0,0).

Verification
REQ-038 IMG_W=4, IMG_H=3. Memory holds pixel value = address. start, win_ready=1, result echoes tap 4 after 1 cycle. Expect: 12 writes, addresses 0..11, wr_data = address, done pulses once, busy low after.
REQ-039 Corner pixel (0,0), same setup. Expect reads at addresses {0,1,4,5} only. win_data taps 0,1,2,3,6 = 00; taps 4,5,7,8 = 00,01,04,05.
REQ-040 Hold win_ready=0 for 20 cycles at pixel (1,1). Expect win_valid held and win_data constant throughout, no reads, no writes. Transfer occurs on the first cycle win_ready=1.
REQ-041 Pulse res_valid during FETCH. Expect no wr_en. Pulse start during busy. Expect frame unaffected, exactly 12 writes total.
REQ-042 Assert reset during FETCH of pixel (2,1). Expect all outputs 0 next cycle. New start writes from address 0, 12 writes total.
REQ-043 Default 640x480, ideal datapath. Expect done after 307200*13 cycles ±2, and last write at address 307199.
